// File: rtl/sram_wrap_pkg.sv
// sram_wrap_pkg: FSM state encoding and lane-merge helper shared by the SRAM wrapper and array.
package sram_wrap_pkg;
   typedef enum logic {S_INIT, S_RUN} state_e;
   localparam int MAX_W = 1024;
   localparam int MAX_L = 128;
   // Callers zero-extend to MAX_W/MAX_L and size-cast the result back to their data width.
   function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_w,
                                                   input logic [MAX_W-1:0] new_w,
                                                   input logic [MAX_L-1:0] mask,
                                                   input int unsigned lw);
      logic [MAX_W-1:0] lane, bm;
      lane = (MAX_W'(1) << lw) - MAX_W'(1);
      bm = '0;
      for (int l = 0; l < MAX_L; l++)
         if (mask[l]) bm = bm | (lane << (l * lw));
      return (old_w & ~bm) | (new_w & bm);
   endfunction
endpackage

// File: rtl/sram_1r1w_array.sv
// sram_1r1w_array: plain storage with a lane-masked write port and a registered read port.
module sram_1r1w_array
   import sram_wrap_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH = 1024,
   parameter int MASK_LANES = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [MASK_LANES-1:0] wmask_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   localparam int LW = DATA_WIDTH / MASK_LANES;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   // Out-of-range addresses only exist for non-power-of-2 depths: drop writes, read zero.
   always_ff @(posedge clk_i) begin
      if (we_i && int'(waddr_i) < DEPTH)
         mem_q[waddr_i] <= DATA_WIDTH'(lane_merge(MAX_W'(mem_q[waddr_i]), MAX_W'(wdata_i),
                                                  MAX_L'(wmask_i), LW));
      if (re_i)
         rdata_q <= (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_1r1w_wrap.sv
// sram_1r1w_wrap: valid/ready 1R1W SRAM wrapper with write-to-read forwarding,
// 1- or 2-cycle read latency and an optional post-reset zeroing sweep.
module sram_1r1w_wrap
   import sram_wrap_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH = 1024,
   parameter int MASK_LANES = 8,
   parameter int READ_LATENCY = 1,
   parameter int INIT_ON_RESET = 1,
   localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  init_done,
   input  logic                  w_valid,
   output logic                  w_ready,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [MASK_LANES-1:0] w_mask,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_valid,
   output logic                  r_ready,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  r_resp_valid,
   output logic [DATA_WIDTH-1:0] r_resp_data
);
   localparam int LW = DATA_WIDTH / MASK_LANES;
   state_e state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic rdy_q, sweep, w_acc, r_acc;
   logic v1_q, seen_q, hit_q;
   logic [MASK_LANES-1:0] fmask_q;
   logic [DATA_WIDTH-1:0] fdata_q, rdata, merged;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
         cnt_q <= '0;
         rdy_q <= (INIT_ON_RESET == 0);
      end else if (state_q == S_INIT) begin
         cnt_q <= cnt_q + ADDR_WIDTH'(1);
         if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q <= S_RUN;
            rdy_q <= 1'b1;
         end
      end
   assign sweep = state_q == S_INIT;
   assign w_acc = w_valid && rdy_q;
   assign r_acc = r_valid && rdy_q;
   assign init_done = rdy_q;
   assign w_ready = rdy_q;
   assign r_ready = rdy_q;
   sram_1r1w_array #(
      .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .MASK_LANES(MASK_LANES), .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk_i(clock),
      .we_i(sweep || w_acc),
      .waddr_i(sweep ? cnt_q : w_addr),
      .wmask_i(sweep ? '1 : w_mask),
      .wdata_i(sweep ? '0 : w_data),
      .re_i(r_acc),
      .raddr_i(r_addr),
      .rdata_o(rdata)
   );
   // Capture any same-edge write to the read address so its lanes override the pre-write data.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         v1_q <= 1'b0;
         seen_q <= 1'b0;
         hit_q <= 1'b0;
         fmask_q <= '0;
         fdata_q <= '0;
      end else begin
         v1_q <= r_acc;
         if (r_acc) begin
            seen_q <= 1'b1;
            hit_q <= w_acc && w_addr == r_addr && int'(r_addr) < DEPTH;
            fmask_q <= w_mask;
            fdata_q <= w_data;
         end
      end
   assign merged = seen_q ? DATA_WIDTH'(lane_merge(MAX_W'(rdata), MAX_W'(fdata_q),
                                                   MAX_L'(hit_q ? fmask_q : '0), LW)) : '0;
   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic v2_q;
         logic [DATA_WIDTH-1:0] d2_q;
         always_ff @(posedge clock or posedge reset)
            if (reset) begin
               v2_q <= 1'b0;
               d2_q <= '0;
            end else begin
               v2_q <= v1_q;
               if (v1_q) d2_q <= merged;
            end
         assign r_resp_valid = v2_q;
         assign r_resp_data = d2_q;
      end else begin : g_lat1
         assign r_resp_valid = v1_q;
         assign r_resp_data = merged;
      end
   endgenerate
endmodule

// File: doc/sram_1r1w_wrap.md
# sram_1r1w_wrap

Parametrised 1-read/1-write SRAM wrapper for cache data and tag arrays. Adds masked lane writes, valid/ready read and write channels, selectable read latency (1 or 2), same-cycle write-to-read forwarding, and an optional post-reset zeroing sweep. Sits between pipeline control logic and a plain synchronous-read memory macro model.

## Interface

Parameters:
- DATA_WIDTH, 64, bits per entry; must be a multiple of MASK_LANES.
- DEPTH, 1024, entries; ADDR_WIDTH = clog2(DEPTH) (local, ≥1).
- MASK_LANES, 8, write-mask lanes; lane width LW = DATA_WIDTH/MASK_LANES.
- READ_LATENCY, 1, 1 or 2 cycles from read accept to response.
- INIT_ON_RESET, 1, 1 = zero all entries after reset before accepting traffic.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- init_done  out  1  high once the array is usable.
- w_valid  in  1  write request.
- w_ready  out  1  write accepted when w_valid && w_ready.
- w_addr  in  ADDR_WIDTH  write address.
- w_mask  in  MASK_LANES  lane i writes bits [i*LW +: LW].
- w_data  in  DATA_WIDTH  write data.
- r_valid  in  1  read request.
- r_ready  out  1  read accepted when r_valid && r_ready.
- r_addr  in  ADDR_WIDTH  read address.
- r_resp_valid  out  1  one-cycle pulse per accepted read.
- r_resp_data  out  DATA_WIDTH  read data, valid only with r_resp_valid; holds last value otherwise.

## Operation

- FSM states S_INIT, S_RUN. Reset state: S_INIT if INIT_ON_RESET=1, else S_RUN.
- S_INIT: init counter starts at 0; each cycle writes all-zero, full-mask to counter address; after writing DEPTH-1 → S_RUN. w_ready=r_ready=init_done=0 throughout.
- S_RUN: w_ready=r_ready=init_done=1 (no backpressure). Stays until reset.
- Write: on accept, lanes with w_mask[i]=1 updated at that clock edge; w_mask=0 is a legal no-op.
- Read: on accept, entry sampled at the accepting edge (pre-write contents). Same-cycle accepted write to same address: lanes with w_mask set take w_data, others take stored value (forward-merge). Writes accepted in later cycles never affect an in-flight read.
- Reads and writes to different addresses are independent; any mix every cycle is legal.
- Asynchronous reset at any time: clears r_resp_valid, pipeline valids, init counter; restarts FSM. Memory contents are not reset except by the sweep; a read/write in flight at reset is dropped.
- Reset values: init_done = w_ready = r_ready = !INIT_ON_RESET; r_resp_valid=0; r_resp_data=0.
- Out-of-range addresses (≥ DEPTH, non-power-of-2 depth): writes ignored, reads return 0.

## Timing

- Read accepted at edge T: r_resp_valid high in cycle after T+READ_LATENCY−1 edges, i.e. LATENCY=1 → visible cycle T+1; LATENCY=2 → cycle T+2. Fully pipelined, one response per cycle.
- Write visible to reads accepted at edge T+1 onward; same-edge reads see it via merge.
- INIT sweep: DEPTH cycles from reset deassertion; init_done rises on the cycle after the last zero write.

## Structure

- Package sram_wrap_pkg: state enum (S_INIT, S_RUN), lane-merge function (old, new, mask, LW) → merged word.
- Sub-module sram_1r1w_array: pure storage, masked write port, registered synchronous read port, no reset. Wrapper holds FSM, forwarding registers (hit flag, mask, data) and optional output stage.

## Test plan

Params DATA_WIDTH=32, DEPTH=16, MASK_LANES=4 unless stated.
- Reset release, INIT_ON_RESET=1 → init_done low 16 cycles then high; read all 16 entries → all 0x00000000.
- Write addr 3 data 0xAABBCCDD mask 0xF, next cycle read 3 → response 0xAABBCCDD after READ_LATENCY (run both 1 and 2).
- Entry 5 = 0x11223344; same cycle write 5 data 0xFFFFFFFF mask 0b0101 and read 5 → response 0x11FF33FF; next read 5 → 0x11FF33FF.
- Back-to-back reads addrs 0..15 every cycle with READ_LATENCY=2 → 16 consecutive r_resp_valid pulses in address order, correct data.
- Read addr 7 accepted, write addr 7 next cycle → response is old value, not new.
- Reset asserted mid-sweep (cycle 8) and mid-read → r_resp_valid drops immediately, sweep restarts at 0, init_done after full 16 cycles.
